fifo_axis_master: RTL and testbench

Parametrised FIFO-to-AXI-Stream master bridge that feeds the HLS accelerator's AXI-Stream slave input. Host-side logic pushes words with a simple write strobe into a circular buffer. Once a full packet of `BURST_LEN` words is buffered, the bridge emits them as one AXI-Stream packet with a generated `tlast`. The bridge runs at full throughput, accepts writes while sending, and can run single-shot or continuously.

---
 rtl/fifo_axis_master.sv | 130 +++++++++++++
 tb/tb_fifo_axis_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_master.sv
// Buffers host writes in a circular store and emits them as fixed-length AXI-Stream packets
// with generated tlast; single-shot (per start) or continuous operation.
module fifo_axis_master #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int BURST_LEN  = 4,
   parameter int CONTINUOUS = 0,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  write,
   input  logic                  start,
   output logic                  full,
   output logic                  empty,
   output logic [AW:0]           level,
   output logic                  overflow,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  pkt_done,
   output logic                  start_accel
);

   localparam int BW = $clog2(BURST_LEN + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;

   logic [DATA_WIDTH-1:0] r_buf [DEPTH];
   logic [1:0]            r_state;
   logic [AW-1:0]         r_wp;
   logic [AW-1:0]         r_rp;
   logic [AW:0]           r_level;
   logic [BW-1:0]         r_beat;
   logic                  r_overflow;
   logic                  r_pkt_done;
   logic [DATA_WIDTH-1:0] r_tdata;
   logic                  r_tvalid;
   logic                  r_tlast;

   logic w_full;
   logic w_push;
   logic w_load;
   logic w_hs;
   logic w_last_hs;

   assign w_full    = (r_level == (AW+1)'(DEPTH));
   assign w_push    = write && !w_full;
   // Output register reloads whenever it is empty or being drained this cycle.
   assign w_load    = (r_state == S_SEND) && (r_beat < BW'(BURST_LEN)) && (!r_tvalid || m_axis_tready);
   assign w_hs      = r_tvalid && m_axis_tready;
   assign w_last_hs = (r_state == S_SEND) && w_hs && r_tlast;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf[r_wp] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_wp       <= '0;
         r_rp       <= '0;
         r_level    <= '0;
         r_beat     <= '0;
         r_overflow <= 1'b0;
         r_pkt_done <= 1'b0;
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         if (write && w_full) begin
            r_overflow <= 1'b1;
         end
         if (w_push) begin
            r_wp <= r_wp + AW'(1);
         end
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_load);

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_FILL;
               end
            end
            S_FILL: begin
               if (r_level >= (AW+1)'(BURST_LEN)) begin
                  r_state <= S_SEND;
                  r_beat  <= '0;
               end
            end
            S_SEND: begin
               if (w_last_hs) begin
                  r_state    <= (CONTINUOUS != 0) ? S_FILL : S_IDLE;
                  r_pkt_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_load) begin
            r_tdata  <= r_buf[r_rp];
            r_tvalid <= 1'b1;
            r_tlast  <= (r_beat == BW'(BURST_LEN - 1));
            r_rp     <= r_rp + AW'(1);
            r_beat   <= r_beat + BW'(1);
         end else if (w_hs) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end
      end
   end

   assign full          = w_full;
   assign empty         = (r_level == '0);
   assign level         = r_level;
   assign overflow      = r_overflow;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign pkt_done      = r_pkt_done;
   assign start_accel   = rst;

endmodule

// File: tb/tb_fifo_axis_master.sv
// Scoreboard bench: one single-shot instance and one continuous instance, each with its own
// expected-beat queue filled by the writers and drained by a negedge monitor.
module tb_fifo_axis_master;

   logic        clk;
   logic        rst0, rst1;
   logic [31:0] din0, din1;
   logic        wr0, wr1, st0, st1, rdy0, rdy1;
   logic        full0, full1, empty0, empty1, ovf0, ovf1;
   logic [4:0]  lvl0, lvl1;
   logic [31:0] td0, td1;
   logic        tv0, tv1, tl0, tl1, pdn0, pdn1, sa0, sa1;

   fifo_axis_master #(.DATA_WIDTH(32), .DEPTH(16), .BURST_LEN(4), .CONTINUOUS(0)) u_dut0 (
      .clk(clk), .rst(rst0), .din(din0), .write(wr0), .start(st0),
      .full(full0), .empty(empty0), .level(lvl0), .overflow(ovf0),
      .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tready(rdy0), .m_axis_tlast(tl0),
      .pkt_done(pdn0), .start_accel(sa0));

   fifo_axis_master #(.DATA_WIDTH(32), .DEPTH(16), .BURST_LEN(4), .CONTINUOUS(1)) u_dut1 (
      .clk(clk), .rst(rst1), .din(din1), .write(wr1), .start(st1),
      .full(full1), .empty(empty1), .level(lvl1), .overflow(ovf1),
      .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(rdy1), .m_axis_tlast(tl1),
      .pkt_done(pdn1), .start_accel(sa1));

   int total = 0;
   int bad   = 0;

   // Reference model: every accepted word is expected once, in order, with tlast on each 4th.
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   int acc0 = 0, acc1 = 0;
   int pk0 = 0, pk1 = 0, hs0 = 0, hs1 = 0;
   bit rnd0 = 1'b0;

   bit          stall0 = 1'b0, plhs0 = 1'b0, plhs1 = 1'b0;
   logic [31:0] pd0;
   logic        pl0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put0(input logic [31:0] d);
      din0 = d;
      wr0  = 1'b1;
      if (q0.size() < 16) begin
         q0.push_back({(acc0 % 4 == 3), d});
         acc0++;
      end
      tick();
      wr0 = 1'b0;
   endtask

   task automatic wait_pk0(input int n);
      int k;
      k = 0;
      while (pk0 < n && k < 300) begin
         tick();
         k++;
      end
      chk("pkt_wait0", 64'(pk0 >= n), 1);
   endtask

   task automatic start0();
      st0 = 1'b1;
      tick();
      st0 = 1'b0;
   endtask

   task automatic reset_check0();
      rst0 = 1'b0;
      tick();
      chk("rst_tvalid0", tv0, 0);
      chk("rst_tlast0", tl0, 0);
      chk("rst_tdata0", td0, 0);
      chk("rst_level0", lvl0, 0);
      chk("rst_empty0", empty0, 1);
      chk("rst_full0", full0, 0);
      chk("rst_ovf0", ovf0, 0);
      chk("rst_pdone0", pdn0, 0);
      chk("rst_sa0", sa0, 0);
      q0.delete();
      acc0 = 0;
      rst0 = 1'b1;
      tick();
      chk("run_sa0", sa0, 1);
   endtask

   initial begin
      rdy0 = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         rdy0 = rnd0 ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : mon0
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst0) begin
            stall0 = 1'b0;
            plhs0  = 1'b0;
         end else begin
            if (stall0) begin
               chk("hold_valid0", tv0, 1);
               chk("hold_data0", td0, pd0);
               chk("hold_last0", tl0, pl0);
            end
            if (plhs0 || pdn0) chk("pkt_done0", pdn0, plhs0);
            if (pdn0) pk0++;
            plhs0 = 1'b0;
            if (tv0 && rdy0) begin
               chk("beat_expected0", 64'(q0.size() != 0), 1);
               if (q0.size() != 0) begin
                  e = q0.pop_front();
                  chk("data0", td0, e[31:0]);
                  chk("last0", tl0, e[32]);
               end
               hs0++;
               plhs0 = tl0;
            end
            stall0 = tv0 && !rdy0;
            pd0    = td0;
            pl0    = tl0;
         end
      end
   end

   initial begin : mon1
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst1) begin
            plhs1 = 1'b0;
         end else begin
            if (plhs1 || pdn1) chk("pkt_done1", pdn1, plhs1);
            if (pdn1) pk1++;
            plhs1 = 1'b0;
            if (tv1 && rdy1) begin
               chk("beat_expected1", 64'(q1.size() != 0), 1);
               if (q1.size() != 0) begin
                  e = q1.pop_front();
                  chk("data1", td1, e[31:0]);
                  chk("last1", tl1, e[32]);
               end
               hs1++;
               plhs1 = tl1;
            end
         end
      end
   end

   initial begin : stim
      int k;
      int pkb;
      int hb;
      rst0 = 1'b0; rst1 = 1'b0;
      din0 = '0;   din1 = '0;
      wr0  = 1'b0; wr1  = 1'b0;
      st0  = 1'b0; st1  = 1'b0;
      rdy1 = 1'b1;
      tick();
      reset_check0();

      // Basic packet with start-to-valid latency and back-to-back beats
      for (int i = 0; i < 4; i++) put0(32'hA0 + 32'(i));
      chk("basic_level_pre", lvl0, 4);
      start0();
      chk("lat_e1_valid", tv0, 0);
      tick();
      chk("lat_e2_valid", tv0, 0);
      tick();
      chk("lat_e3_valid", tv0, 1);
      chk("first_data", td0, 32'hA0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("burst_valid", tv0, 1);
      end
      tick();
      chk("basic_pkt_done", pdn0, 1);
      chk("basic_valid_off", tv0, 0);
      chk("basic_level", lvl0, 0);
      chk("basic_empty", empty0, 1);
      repeat (3) tick();
      chk("idle_no_valid", tv0, 0);

      // Backpressure with random tready
      pkb = pk0;
      for (int i = 0; i < 4; i++) put0($urandom);
      rnd0 = 1'b1;
      start0();
      wait_pk0(pkb + 1);
      rnd0 = 1'b0;
      chk("bp_queue_left", q0.size(), 0);
      chk("bp_level", lvl0, 0);

      // Simultaneous push and pop at level 5
      for (int i = 0; i < 5; i++) put0($urandom);
      start0();
      tick();
      chk("pp_level_pre", lvl0, 5);
      put0($urandom);
      chk("pp_level", lvl0, 5);
      pkb = pk0;
      wait_pk0(pkb + 1);
      chk("pp_level_after", lvl0, 2);
      put0($urandom);
      put0($urandom);
      start0();
      wait_pk0(pkb + 2);
      chk("pp_queue_left", q0.size(), 0);
      chk("pp_level_end", lvl0, 0);

      // Full and overflow, then drain across pointer wrap with backpressure
      reset_check0();
      for (int i = 0; i < 16; i++) put0(32'h100 + 32'(i));
      chk("full_after16", full0, 1);
      chk("level16", lvl0, 16);
      chk("no_ovf_yet", ovf0, 0);
      put0(32'hDEAD);
      chk("full_after17", full0, 1);
      chk("level_after17", lvl0, 16);
      chk("ovf_set", ovf0, 1);
      rnd0 = 1'b1;
      pkb = pk0;
      for (int p = 1; p <= 4; p++) begin
         start0();
         wait_pk0(pkb + p);
      end
      rnd0 = 1'b0;
      chk("drain_level", lvl0, 0);
      chk("drain_queue", q0.size(), 0);
      chk("ovf_sticky", ovf0, 1);

      // Reset in the middle of a packet
      for (int i = 0; i < 4; i++) put0($urandom);
      hb = hs0;
      start0();
      k = 0;
      while (hs0 < hb + 2 && k < 50) begin
         tick();
         k++;
      end
      chk("mid_two_beats", 64'(hs0 >= hb + 2), 1);
      reset_check0();
      for (int i = 0; i < 4; i++) put0($urandom);
      repeat (4) tick();
      chk("post_rst_idle", tv0, 0);
      chk("post_rst_level", lvl0, 4);
      pkb = pk0;
      start0();
      wait_pk0(pkb + 1);
      chk("post_rst_queue", q0.size(), 0);
      chk("post_rst_level_end", lvl0, 0);

      // Continuous instance: 40 words streamed while sending
      rst1 = 1'b0;
      tick();
      chk("rst_tvalid1", tv1, 0);
      chk("rst_empty1", empty1, 1);
      chk("rst_sa1", sa1, 0);
      rst1 = 1'b1;
      tick();
      pkb = pk1;
      st1 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         k = 0;
         while (full1 && k < 100) begin
            tick();
            st1 = 1'b0;
            k++;
         end
         din1 = $urandom;
         wr1  = 1'b1;
         q1.push_back({(acc1 % 4 == 3), din1});
         acc1++;
         tick();
         wr1 = 1'b0;
         st1 = 1'b0;
      end
      k = 0;
      while (q1.size() != 0 && k < 400) begin
         tick();
         k++;
      end
      chk("cont_drain", q1.size(), 0);
      repeat (3) tick();
      chk("cont_packets", pk1 - pkb, 10);
      chk("cont_ovf", ovf1, 0);
      chk("cont_level", lvl1, 0);
      for (int i = 0; i < 4; i++) begin
         din1 = $urandom;
         wr1  = 1'b1;
         q1.push_back({(acc1 % 4 == 3), din1});
         acc1++;
         tick();
         wr1 = 1'b0;
      end
      k = 0;
      while (pk1 < pkb + 11 && k < 100) begin
         tick();
         k++;
      end
      chk("cont_no_restart_needed", pk1 - pkb, 11);
      chk("cont_queue_end", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
